sprite_rom_arbiter: RTL
=======================

# sprite_rom_arbiter

Shares one synchronous sprite ROM among up to NUM_REQ sprite renderers (scanout, player sprites, overlay) on the VGA pixel clock. Each cycle it grants at most one pending address request, with round-robin fairness and an optional fixed-priority override for requester 0. It drives the ROM address and routes the returned palette index back to the requester that issued it, using a tag pipeline matched to the ROM read latency.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_W, 17: ROM address width
- DATA_W, 4: ROM data width (palette index)
- ROM_LAT, 1: edges from rom_address update until rom_q can be sampled; 1..3. Use 1 for a negedge-clocked ROM.

Ports:
- vga_clk  in  1  pixel clock. All state is posedge.
- reset_n  in  1  asynchronous, active-low reset
- hp_en  in  1  when 1, requester 0 has absolute priority
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid, hp_en and rr_ptr
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  DATA_W  ROM read data
- rsp_valid  out  NUM_REQ  one-hot, registered; data returned to requester i
- rsp_data  out  DATA_W  registered, shared by all requesters
- grant_id  out  $clog2(NUM_REQ)  registered index of the last accepted requester

## Operation
- A request is accepted on a posedge where req_valid[i] and req_ready[i] are both 1. The requester holds req_addr stable until it is accepted.
- Grant selection, evaluated each cycle:
  - If hp_en is 1 and req_valid[0] is 1, grant 0.
  - Otherwise, search from (rr_ptr+1) mod NUM_REQ upward, wrapping, and grant the first requester with valid set.
  - If no requester is valid, req_ready is all 0.
- At most one req_ready bit is set per cycle. req_ready[i] is never 1 while req_valid[i] is 0.
- rr_ptr updates to the granted index on every accept, including a high-priority grant to 0. It holds when nothing is accepted.
- On accept:
  - rom_address <= selected req_addr.
  - grant_id <= index.
  - tag stage 0 <= {1, index}.
- With no accept, rom_address holds its value and tag stage 0 <= {0, x}.
- Tag pipeline: ROM_LAT stages, shifted every edge, with no stalls. The ROM is always ready.
- At the last tag stage, rsp_data <= rom_q, and rsp_valid <= onehot(tag index) gated by the tag valid bit, otherwise 0.
- Fairness: with hp_en=0, any continuously valid requester is granted within NUM_REQ cycles. With hp_en=1, a continuously valid requester 0 starves all others; this is intentional for scanout.

## Timing
- Throughput: one accept per cycle, fully pipelined.
- Latency: an accept at edge k gives rsp_valid high for exactly one cycle, from edge k+ROM_LAT to edge k+ROM_LAT+1. For ROM_LAT=1 that is 2 edges from accept to rsp_valid falling.
- Back-to-back accepts to different requesters return in order, one per cycle, each carrying its own tag.
- Reset (reset_n low, asynchronous):
  - rom_address=0, rsp_valid=0, rsp_data=0, grant_id=0.
  - All tag valid bits cleared.
  - rr_ptr=NUM_REQ-1, so requester 0 wins the first round-robin search.
  - req_ready forced to 0.
- Reset during in-flight reads discards them; no rsp_valid is produced for those reads after reset releases.
- Simultaneous events: a new accept and a response retiring in the same cycle are independent and both occur.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Test plan
- Reset mid-flight: with ROM_LAT=2, accept at edge 5, assert reset_n=0 at edge 6, release at edge 8 -> no rsp_valid ever appears; all outputs read 0 during reset; the first post-reset grant goes to requester 0.
- Single requester: req_valid=0b0010, req_addr[1]=0x1A2B3, ROM model returns addr[3:0] -> req_ready=0b0010 in the same cycle; rom_address=0x1A2B3 after the edge; with ROM_LAT=1, rsp_valid=0b0010 and rsp_data=0x3 one edge later, for exactly one cycle.
- Round-robin: all four requesters valid continuously, hp_en=0 -> grant order 0,1,2,3,0,1,... The rsp_valid one-hot sequence matches the grant order delayed by ROM_LAT edges, and each rsp_data matches its own address.
- Priority override: hp_en=1, req_valid=0b1111 for 6 cycles -> requester 0 is granted all 6. Then drop req_valid[0] -> next grant goes to requester 1 (rr_ptr=0), then 2.
- Sparse/wrap: rr_ptr=3 with only requester 2 valid -> search wraps through 0 and 1 and grants 2. No request for 3 cycles -> rom_address holds, rsp_valid stays 0.
- Latency sweep: repeat the single-requester scenario with ROM_LAT=1,2,3 -> rsp_valid rises exactly ROM_LAT edges after the accept edge, with no duplicate or dropped responses.

Source files
------------

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: request/response bus between sprite renderers, the arbiter and the ROM.
//   hp_en        requester 0 absolute priority
//   req_valid    per-requester read request
//   req_addr     packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready    one-hot grant
//   rom_address  ROM address, rom_q ROM read data
//   rsp_valid    one-hot response strobe, rsp_data shared response data
//   grant_id     index of the last accepted requester
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 4
);
  localparam int IW = $clog2(NUM_REQ);
  logic                      hp_en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [IW-1:0]             grant_id;
  modport slave (
    input  hp_en, req_valid, req_addr, rom_q,
    output req_ready, rom_address, rsp_valid, rsp_data, grant_id
  );
  modport master (
    output hp_en, req_valid, req_addr, rom_q,
    input  req_ready, rom_address, rsp_valid, rsp_data, grant_id
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin arbiter sharing one synchronous sprite ROM among NUM_REQ renderers.
//   vga_clk  pixel clock, all state on posedge
//   reset_n  asynchronous active-low reset
//   bus      sprite_rom_arbiter_if slave: requests, ROM address/data, tagged responses
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input logic vga_clk,
  input logic reset_n,
  sprite_rom_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel;
  logic          acc;
  logic [ROM_LAT-1:0] tag_v;
  logic [IW-1:0]      tag_id [ROM_LAT];
  // Scan farthest-first so the nearest valid requester after rr_ptr is assigned last and wins.
  always_comb begin
    sel = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) sel = IW'((int'(rr_ptr) + k) % NUM_REQ);
    if (bus.hp_en && bus.req_valid[0]) sel = '0;
  end
  assign acc = reset_n && |bus.req_valid;
  assign bus.req_ready = acc ? NUM_REQ'(1) << sel : '0;
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr          <= IW'(NUM_REQ - 1);
      bus.rom_address <= '0;
      bus.grant_id    <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_data    <= '0;
      tag_v           <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_id[i] <= '0;
    end else begin
      if (acc) begin
        rr_ptr          <= sel;
        bus.grant_id    <= sel;
        bus.rom_address <= bus.req_addr[sel*ADDR_W +: ADDR_W];
      end
      tag_v[0]  <= acc;
      tag_id[0] <= sel;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      bus.rsp_valid <= tag_v[ROM_LAT-1] ? NUM_REQ'(1) << tag_id[ROM_LAT-1] : '0;
      if (tag_v[ROM_LAT-1]) bus.rsp_data <= bus.rom_q;
    end
  end
endmodule
